// File: rtl/hist_eq_pkg.sv
// Shared types and constants for the two-pass histogram-equalization core.
package hist_eq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        SCAN,
        BUILD,
        MAP
    } state_e;

    localparam logic MODE_EQ  = 1'b0;
    localparam logic MODE_BYP = 1'b1;

    function automatic int unsigned maxv(input int unsigned pix_w);
        return (32'd1 << pix_w) - 32'd1;
    endfunction

endpackage

// File: rtl/hist_eq_serial_div.sv
// Restoring serial divider: one quotient bit per cycle, quotient truncated to Q_W bits.
module hist_eq_serial_div
    import hist_eq_pkg::*;
#(
    parameter int unsigned NUM_W = 28,
    parameter int unsigned DEN_W = 20,
    parameter int unsigned Q_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [NUM_W-1:0] num_i,
    input  logic [DEN_W-1:0] den_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [Q_W-1:0]   quo_o
);

    localparam int unsigned CW = $clog2(NUM_W + 1);

    logic [NUM_W-1:0] quo_q, quo_d;
    logic [DEN_W-1:0] rem_q, rem_d;
    logic [DEN_W-1:0] den_q, den_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [DEN_W:0]   rem_sh;

    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        den_d  = den_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        rem_sh = {rem_q, quo_q[NUM_W-1]};
        if (start_i) begin
            quo_d  = num_i;
            rem_d  = '0;
            den_d  = den_i;
            cnt_d  = CW'(NUM_W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            // Dividend bits shift out of the top of quo_q while quotient bits enter at the bottom.
            if (rem_sh >= {1'b0, den_q}) begin
                rem_d = DEN_W'(rem_sh - {1'b0, den_q});
                quo_d = {quo_q[NUM_W-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[DEN_W-1:0];
                quo_d = {quo_q[NUM_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            quo_q  <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            den_q  <= den_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign quo_o  = quo_q[Q_W-1:0];

endmodule

// File: rtl/hist_eq_stream_core.sv
// Two-pass histogram equalization: pass 1 builds the histogram, the LUT is derived from
// the CDF with a serial divider, pass 2 remaps the stream through the LUT (or bypasses it).
module hist_eq_stream_core
    import hist_eq_pkg::*;
#(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned CNT_W = 20
) (
    input  logic             S_AXI_ACLK,
    input  logic             S_AXI_ARESETN,
    input  logic             cfg_start,
    input  logic             cfg_mode,
    input  logic [CNT_W-1:0] cfg_total,
    output logic             stat_busy,
    output logic             stat_done,
    output logic             stat_frame_err,
    input  logic [PIX_W-1:0] S_AXIS_TDATA,
    input  logic             S_AXIS_TVALID,
    input  logic             S_AXIS_TLAST,
    output logic             S_AXIS_TREADY,
    output logic [PIX_W-1:0] M_AXIS_TDATA,
    output logic             M_AXIS_TVALID,
    output logic             M_AXIS_TLAST,
    input  logic             M_AXIS_TREADY
);

    localparam int unsigned     BINS  = 1 << PIX_W;
    localparam int unsigned     NUM_W = CNT_W + PIX_W;
    localparam logic [PIX_W-1:0] MAXV = PIX_W'(maxv(PIX_W));

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] ntot_q, ntot_d;
    logic [CNT_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cmin_q, cmin_d;
    logic [PIX_W-1:0] idx_q, idx_d;
    logic             found_q, found_d;
    logic             div_run_q, div_run_d;
    logic             in_done_q, in_done_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             mvalid_q, mvalid_d;
    logic             mlast_q, mlast_d;
    logic [PIX_W-1:0] mdata_q, mdata_d;

    logic [CNT_W-1:0] hist_mem [BINS];
    logic [PIX_W-1:0] lut_mem  [BINS];

    logic             hist_we, lut_we;
    logic [PIX_W-1:0] hist_wa, lut_wa;
    logic [CNT_W-1:0] hist_wd;
    logic [PIX_W-1:0] lut_wd;

    logic             s_ready, s_fire, at_end, tlast_err;
    logic [CNT_W-1:0] beat_n, hist_pix, hist_idx, cdf_next, cdf_rd;
    logic [PIX_W-1:0] div_idx, div_quo;
    logic [NUM_W-1:0] div_num;
    logic [CNT_W-1:0] div_den;
    logic             div_start, div_busy, div_done;

    assign beat_n    = n_q + CNT_W'(1);
    assign at_end    = (beat_n == total_q);
    assign tlast_err = (S_AXIS_TLAST != at_end);
    assign s_fire    = S_AXIS_TVALID && s_ready;

    assign hist_pix = hist_mem[S_AXIS_TDATA];
    assign hist_idx = hist_mem[idx_q];
    assign cdf_next = sum_q + hist_idx;

    // A new division is launched in the same cycle the previous result is written back.
    assign div_idx = div_run_q ? idx_q + PIX_W'(1) : idx_q;
    assign cdf_rd  = hist_mem[div_idx];
    assign div_num = (cdf_rd >= cmin_q) ? NUM_W'(cdf_rd - cmin_q) * NUM_W'(MAXV) : '0;
    assign div_den = ntot_q - cmin_q;

    hist_eq_serial_div #(
        .NUM_W(NUM_W),
        .DEN_W(CNT_W),
        .Q_W  (PIX_W)
    ) u_div (
        .clk_i  (S_AXI_ACLK),
        .rst_ni (S_AXI_ARESETN),
        .start_i(div_start),
        .num_i  (div_num),
        .den_i  (div_den),
        .busy_o (div_busy),
        .done_o (div_done),
        .quo_o  (div_quo)
    );

    always_comb begin
        case (state_q)
            ACCUM:   s_ready = 1'b1;
            MAP:     s_ready = !in_done_q && (M_AXIS_TREADY || !mvalid_q);
            default: s_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        total_d   = total_q;
        n_d       = n_q;
        ntot_d    = ntot_q;
        sum_d     = sum_q;
        cmin_d    = cmin_q;
        idx_d     = idx_q;
        found_d   = found_q;
        div_run_d = div_run_q;
        in_done_d = in_done_q;
        err_d     = err_q;
        done_d    = 1'b0;
        mvalid_d  = mvalid_q;
        mlast_d   = mlast_q;
        mdata_d   = mdata_q;
        hist_we   = 1'b0;
        hist_wa   = idx_q;
        hist_wd   = '0;
        lut_we    = 1'b0;
        lut_wa    = idx_q;
        lut_wd    = '0;
        div_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    mode_d    = cfg_mode;
                    total_d   = (cfg_total == '0) ? CNT_W'(1) : cfg_total;
                    err_d     = 1'b0;
                    n_d       = '0;
                    idx_d     = '0;
                    in_done_d = 1'b0;
                    state_d   = (cfg_mode == MODE_BYP) ? MAP : CLEAR;
                end
            end
            CLEAR: begin
                hist_we = 1'b1;
                idx_d   = idx_q + PIX_W'(1);
                if (idx_q == MAXV) state_d = ACCUM;
            end
            ACCUM: begin
                if (s_fire) begin
                    hist_we = 1'b1;
                    hist_wa = S_AXIS_TDATA;
                    hist_wd = hist_pix + CNT_W'(1);
                    n_d     = beat_n;
                    if (tlast_err) err_d = 1'b1;
                    if (at_end || S_AXIS_TLAST) begin
                        ntot_d  = beat_n;
                        idx_d   = '0;
                        sum_d   = '0;
                        found_d = 1'b0;
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                hist_we = 1'b1;
                hist_wd = cdf_next;
                sum_d   = cdf_next;
                if (!found_q && hist_idx != '0) begin
                    found_d = 1'b1;
                    cmin_d  = cdf_next;
                end
                idx_d = idx_q + PIX_W'(1);
                if (idx_q == MAXV) begin
                    div_run_d = 1'b0;
                    state_d   = BUILD;
                end
            end
            BUILD: begin
                if (!div_run_q && !div_busy) begin
                    div_start = 1'b1;
                    div_run_d = 1'b1;
                end else if (div_done) begin
                    lut_we = 1'b1;
                    // N == cdf_min means a single-valued frame: fall back to identity.
                    lut_wd = (ntot_q == cmin_q) ? idx_q : div_quo;
                    if (idx_q == MAXV) begin
                        n_d       = '0;
                        in_done_d = 1'b0;
                        state_d   = MAP;
                    end else begin
                        idx_d     = idx_q + PIX_W'(1);
                        div_start = 1'b1;
                    end
                end
            end
            MAP: begin
                if (M_AXIS_TREADY || !mvalid_q) begin
                    mvalid_d = s_fire;
                    if (s_fire) begin
                        mdata_d = (mode_q == MODE_BYP) ? S_AXIS_TDATA : lut_mem[S_AXIS_TDATA];
                        mlast_d = at_end;
                        n_d     = beat_n;
                        if (tlast_err) err_d = 1'b1;
                        if (at_end) in_done_d = 1'b1;
                    end
                end
                if (mvalid_q && M_AXIS_TREADY && mlast_q) begin
                    mlast_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state_q   <= IDLE;
            mode_q    <= MODE_EQ;
            total_q   <= '0;
            n_q       <= '0;
            ntot_q    <= '0;
            sum_q     <= '0;
            cmin_q    <= '0;
            idx_q     <= '0;
            found_q   <= 1'b0;
            div_run_q <= 1'b0;
            in_done_q <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            mvalid_q  <= 1'b0;
            mlast_q   <= 1'b0;
            mdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            total_q   <= total_d;
            n_q       <= n_d;
            ntot_q    <= ntot_d;
            sum_q     <= sum_d;
            cmin_q    <= cmin_d;
            idx_q     <= idx_d;
            found_q   <= found_d;
            div_run_q <= div_run_d;
            in_done_q <= in_done_d;
            err_q     <= err_d;
            done_q    <= done_d;
            mvalid_q  <= mvalid_d;
            mlast_q   <= mlast_d;
            mdata_q   <= mdata_d;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (hist_we) hist_mem[hist_wa] <= hist_wd;
        if (lut_we)  lut_mem[lut_wa]   <= lut_wd;
    end

    assign S_AXIS_TREADY  = s_ready;
    assign M_AXIS_TDATA   = mdata_q;
    assign M_AXIS_TVALID  = mvalid_q;
    assign M_AXIS_TLAST   = mlast_q;
    assign stat_busy      = (state_q != IDLE);
    assign stat_done      = done_q;
    assign stat_frame_err = err_q;

endmodule

// File: tb/tb_hist_eq_stream_core.sv
// Directed bench for hist_eq_stream_core: equalize, identity, bypass, frame errors, stalls, reset.
module tb_hist_eq_stream_core;
    import hist_eq_pkg::*;

    localparam int unsigned PW = 8;
    localparam int unsigned CW = 20;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_mode = 1'b0;
    logic [CW-1:0] cfg_total = '0;
    logic          stat_busy, stat_done, stat_frame_err;
    logic [PW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [PW-1:0] m_data;
    logic          m_valid, m_last;
    logic          m_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int got;

    logic [PW-1:0] in_pix  [0:1023];
    logic [PW-1:0] out_pix [0:1023];
    logic          out_last[0:1023];
    int            in_cyc  [0:1023];
    int            out_cyc [0:1023];

    hist_eq_stream_core #(
        .PIX_W(PW),
        .CNT_W(CW)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rstn),
        .cfg_start     (cfg_start),
        .cfg_mode      (cfg_mode),
        .cfg_total     (cfg_total),
        .stat_busy     (stat_busy),
        .stat_done     (stat_done),
        .stat_frame_err(stat_frame_err),
        .S_AXIS_TDATA  (s_data),
        .S_AXIS_TVALID (s_valid),
        .S_AXIS_TLAST  (s_last),
        .S_AXIS_TREADY (s_ready),
        .M_AXIS_TDATA  (m_data),
        .M_AXIS_TVALID (m_valid),
        .M_AXIS_TLAST  (m_last),
        .M_AXIS_TREADY (m_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (stat_done) done_cnt <= done_cnt + 1;
        if (stat_busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic pulse_start(input logic mode, input int total);
        cfg_mode  = mode;
        cfg_total = CW'(total);
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    // Streams in_pix[0..nbeats-1] and collects nexp output beats, checking stall stability.
    task automatic run_frame(input int nbeats, input int last_at, input int rdy_pct,
                             input int nexp, input int budget);
        int   sent;
        int   c;
        logic sfire, mfire, pstall;
        logic [PW-1:0] pdata;
        logic plast;
        sent = 0;
        c = 0;
        got = 0;
        pstall = 1'b0;
        pdata = '0;
        plast = 1'b0;
        while ((sent < nbeats || got < nexp) && c < budget) begin
            s_valid = (sent < nbeats);
            s_data  = (sent < nbeats) ? in_pix[sent] : '0;
            s_last  = (sent < nbeats) && (sent == last_at);
            m_ready = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            sfire = s_valid && s_ready;
            mfire = m_valid && m_ready;
            if (pstall) begin
                checks++;
                if (m_data !== pdata || m_last !== plast) begin
                    errors++;
                    $display("FAIL stall_stable data %0d last %0b required %0d last %0b",
                             m_data, m_last, pdata, plast);
                end
            end
            pstall = m_valid && !m_ready;
            pdata  = m_data;
            plast  = m_last;
            if (mfire && got < 1024) begin
                out_pix[got]  = m_data;
                out_last[got] = m_last;
                out_cyc[got]  = c;
                got++;
            end
            if (sfire) begin
                in_cyc[sent] = c;
                sent++;
            end
            @(posedge clk); #1;
            c++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        checks++;
        if (c >= budget) begin
            errors++;
            $display("FAIL run_frame_timeout sent %0d got %0d required %0d and %0d",
                     sent, got, nbeats, nexp);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({s_ready, m_valid, m_data, m_last, stat_busy, stat_done, stat_frame_err} !== '0) begin
            errors++;
            $display("FAIL reset_values got %b required all zero",
                     {s_ready, m_valid, m_data, m_last, stat_busy, stat_done, stat_frame_err});
        end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic eq_two_level(input string tag);
        int base;
        logic [PW-1:0] exp;
        base = done_cnt;
        for (int i = 0; i < 16; i++) in_pix[i] = (i < 8) ? 8'd10 : 8'd200;
        pulse_start(MODE_EQ, 16);
        run_frame(16, 15, 100, 0, 2000);
        pulse_start(MODE_BYP, 5);
        run_frame(16, 15, 100, 16, 12000);
        checks++;
        if (stat_done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_after_last got %b required 1", tag, stat_done);
        end
        checks++;
        if (got != 16) begin
            errors++;
            $display("FAIL %s out_count got %0d required 16", tag, got);
        end
        for (int i = 0; i < 16; i++) begin
            exp = (i < 8) ? 8'd0 : 8'd255;
            checks++;
            if (out_pix[i] !== exp || out_last[i] !== (i == 15)) begin
                errors++;
                $display("FAIL %s pix%0d got %0d last %b required %0d last %b",
                         tag, i, out_pix[i], out_last[i], exp, (i == 15));
            end
        end
        checks++;
        if (stat_frame_err !== 1'b0) begin
            errors++;
            $display("FAIL %s frame_err got %b required 0", tag, stat_frame_err);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cnt - base != 1) begin
            errors++;
            $display("FAIL %s done_pulses got %0d required 1", tag, done_cnt - base);
        end
    endtask

    task automatic test_two_level();
        eq_two_level("two_level");
    endtask

    task automatic test_constant();
        for (int i = 0; i < 16; i++) in_pix[i] = 8'd77;
        pulse_start(MODE_EQ, 16);
        run_frame(16, 15, 100, 0, 2000);
        run_frame(16, 15, 100, 16, 12000);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (out_pix[i] !== 8'd77) begin
                errors++;
                $display("FAIL constant pix%0d got %0d required 77", i, out_pix[i]);
            end
        end
        checks++;
        if (stat_frame_err !== 1'b0) begin
            errors++;
            $display("FAIL constant frame_err got %b required 0", stat_frame_err);
        end
    endtask

    task automatic test_bypass();
        int bbase;
        for (int i = 0; i < 16; i++) in_pix[i] = PW'(i);
        bbase = busy_cnt;
        pulse_start(MODE_BYP, 16);
        run_frame(16, 15, 100, 16, 200);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (out_pix[i] !== PW'(i) || out_cyc[i] != in_cyc[i] + 1 ||
                out_last[i] !== (i == 15)) begin
                errors++;
                $display("FAIL bypass pix%0d got %0d lat %0d last %b required %0d lat 1 last %b",
                         i, out_pix[i], out_cyc[i] - in_cyc[i], out_last[i], i, (i == 15));
            end
        end
        checks++;
        if (busy_cnt - bbase != 17) begin
            errors++;
            $display("FAIL bypass_busy_cycles got %0d required 17", busy_cnt - bbase);
        end
    endtask

    task automatic test_early_tlast();
        int base;
        logic [PW-1:0] exp;
        base = done_cnt;
        for (int i = 0; i < 16; i++)
            in_pix[i] = (i % 3 == 0) ? 8'd10 : (i % 3 == 1) ? 8'd100 : 8'd200;
        pulse_start(MODE_EQ, 16);
        run_frame(12, 11, 100, 0, 2000);
        checks++;
        if (stat_frame_err !== 1'b1) begin
            errors++;
            $display("FAIL early_err_set got %b required 1", stat_frame_err);
        end
        run_frame(16, 15, 100, 16, 12000);
        // N = 12, cdf_min = 4: bin 100 has cdf 8 -> 4*255/8 = 127
        for (int i = 0; i < 16; i++) begin
            exp = (i % 3 == 0) ? 8'd0 : (i % 3 == 1) ? 8'd127 : 8'd255;
            checks++;
            if (out_pix[i] !== exp) begin
                errors++;
                $display("FAIL early pix%0d got %0d required %0d", i, out_pix[i], exp);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (stat_frame_err !== 1'b1 || done_cnt - base != 1) begin
            errors++;
            $display("FAIL early_err_sticky err %b done %0d required err 1 done 1",
                     stat_frame_err, done_cnt - base);
        end
        in_pix[0] = 8'd33;
        in_pix[1] = 8'd44;
        pulse_start(MODE_BYP, 2);
        checks++;
        if (stat_frame_err !== 1'b0) begin
            errors++;
            $display("FAIL early_err_clear got %b required 0", stat_frame_err);
        end
        run_frame(2, 1, 100, 2, 200);
    endtask

    task automatic test_random_stall();
        int h    [256];
        int cdfv [256];
        int lutm [256];
        int cmin;
        int cdf;
        bit found;
        int n;
        n = 300;
        for (int b = 0; b < 256; b++) h[b] = 0;
        for (int i = 0; i < n; i++) begin
            in_pix[i] = PW'($urandom_range(180, 40));
            h[in_pix[i]]++;
        end
        cdf = 0;
        found = 1'b0;
        cmin = 0;
        for (int b = 0; b < 256; b++) begin
            cdf += h[b];
            cdfv[b] = cdf;
            if (!found && h[b] != 0) begin
                found = 1'b1;
                cmin = cdf;
            end
        end
        for (int b = 0; b < 256; b++) begin
            if (n == cmin) lutm[b] = b;
            else if (cdfv[b] < cmin) lutm[b] = 0;
            else lutm[b] = ((cdfv[b] - cmin) * 255) / (n - cmin);
        end
        pulse_start(MODE_EQ, n);
        run_frame(n, n - 1, 100, 0, 2000);
        run_frame(n, n - 1, 50, n, 15000);
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL random_count got %0d required %0d", got, n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (out_pix[i] !== PW'(lutm[in_pix[i]]) || out_last[i] !== (i == n - 1)) begin
                errors++;
                $display("FAIL random pix%0d in %0d got %0d last %b required %0d last %b",
                         i, in_pix[i], out_pix[i], out_last[i], lutm[in_pix[i]], (i == n - 1));
            end
        end
    endtask

    task automatic test_reset_mid_accum();
        for (int i = 0; i < 16; i++) in_pix[i] = 8'd150;
        pulse_start(MODE_EQ, 16);
        run_frame(5, -1, 100, 0, 2000);
        rstn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({s_ready, m_valid, m_data, m_last, stat_busy, stat_done, stat_frame_err} !== '0) begin
            errors++;
            $display("FAIL mid_reset_values got %b required all zero",
                     {s_ready, m_valid, m_data, m_last, stat_busy, stat_done, stat_frame_err});
        end
        rstn = 1'b1;
        eq_two_level("after_reset");
    endtask

    initial begin
        test_reset();
        test_two_level();
        test_constant();
        test_bypass();
        test_early_tlast();
        test_random_stall();
        test_reset_mid_accum();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
